// File: rtl/usbf_ep_arb.sv
// Round-robin arbiter granting one endpoint at a time access to the shared
// buffer port, and counting the beats of the transfer it has granted.
module usbf_ep_arb #(
  parameter int IDW = 2,
  parameter int LW  = 10,
  localparam int NEP = 2 ** IDW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NEP-1:0]    req,
  input  logic [NEP*LW-1:0] len,
  input  logic              abort,
  input  logic              mem_rdy,
  output logic [NEP-1:0]    gnt,
  output logic [IDW-1:0]    gnt_id,
  output logic              busy,
  output logic              mem_vld,
  output logic [LW-1:0]     beat_cnt,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t         state, state_next;
  logic [IDW-1:0] last_reg;
  logic [IDW-1:0] gnt_id_reg;
  logic [LW-1:0]  remaining_reg;
  logic [LW-1:0]  beat_cnt_reg;
  logic           err_reg;

  logic           found;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] idx;
  logic [LW-1:0]  len_sel;
  logic           beat;
  logic           final_beat;

  // Search starts just after the last winner; k == NEP wraps back to it.
  always_comb begin
    found  = 1'b0;
    winner = last_reg;
    idx    = last_reg;
    for (int k = 1; k <= NEP; k++) begin
      idx = last_reg + IDW'(k);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign len_sel    = len[winner*LW +: LW];
  assign beat       = (state == XFER) && mem_rdy;
  assign final_beat = beat && (remaining_reg == LW'(1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (found) state_next = (len_sel == '0) ? DONE : XFER;
      XFER: if (final_beat || abort) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_reg      <= IDW'(NEP - 1);
      gnt_id_reg    <= '0;
      remaining_reg <= '0;
      beat_cnt_reg  <= '0;
      err_reg       <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (found) begin
            gnt_id_reg    <= winner;
            remaining_reg <= len_sel;
            beat_cnt_reg  <= '0;
            err_reg       <= 1'b0;
          end
        end
        XFER: begin
          if (beat) begin
            remaining_reg <= remaining_reg - LW'(1);
            beat_cnt_reg  <= beat_cnt_reg + LW'(1);
          end
          // A final beat wins over a simultaneous abort.
          if (abort && !final_beat) err_reg <= 1'b1;
        end
        DONE: last_reg <= gnt_id_reg;
        default: ;
      endcase
    end
  end

  always_comb begin
    gnt = '0;
    if (state == XFER) gnt[gnt_id_reg] = 1'b1;
  end

  assign gnt_id   = gnt_id_reg;
  assign busy     = (state == XFER);
  assign mem_vld  = (state == XFER);
  assign beat_cnt = beat_cnt_reg;
  assign done     = (state == DONE);
  assign err      = (state == DONE) && err_reg;

endmodule

// File: tb/tb_usbf_ep_arb.sv
// Bench for usbf_ep_arb: scenario tasks push expected transfer results;
// a done-pulse monitor pops and compares them.
module tb_usbf_ep_arb;
  localparam int IDW = 2;
  localparam int LW  = 10;
  localparam int NEP = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NEP-1:0]    req;
  logic [NEP*LW-1:0] len;
  logic              abort;
  logic              mem_rdy;
  logic [NEP-1:0]    gnt;
  logic [IDW-1:0]    gnt_id;
  logic              busy;
  logic              mem_vld;
  logic [LW-1:0]     beat_cnt;
  logic              done;
  logic              err;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [IDW-1:0] id;
    logic [LW-1:0]  beats;
    logic           err;
  } exp_t;
  exp_t sb[$];

  usbf_ep_arb #(.IDW(IDW), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .len(len), .abort(abort),
    .mem_rdy(mem_rdy), .gnt(gnt), .gnt_id(gnt_id), .busy(busy),
    .mem_vld(mem_vld), .beat_cnt(beat_cnt), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done: got done=1 id=%0d, required no pending transfer", gnt_id);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (gnt_id !== e.id || beat_cnt !== e.beats || err !== e.err) begin
          miscompares++;
          $display("FAIL done_result: got id=%0d beats=%0d err=%0d, required id=%0d beats=%0d err=%0d",
                   gnt_id, beat_cnt, err, e.id, e.beats, e.err);
        end else
          $display("xfer id=%0d beats=%0d err=%0d ok", gnt_id, beat_cnt, err);
      end
    end
  end

  task automatic set_len(input int i, input int v);
    len[i*LW +: LW] = LW'(v);
  endtask

  task automatic push(input int id, input int beats, input logic e);
    exp_t x;
    x.id = IDW'(id); x.beats = LW'(beats); x.err = e;
    sb.push_back(x);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req = '0; len = '0; abort = 1'b0; mem_rdy = 1'b1;
    @(negedge clk);
    vectors++;
    if ({gnt, gnt_id, busy, mem_vld, beat_cnt, done, err} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got gnt=%b id=%0d busy=%b vld=%b cnt=%0d done=%b err=%b, required all 0",
               gnt, gnt_id, busy, mem_vld, beat_cnt, done, err);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fairness;
    int order[5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NEP; i++) set_len(i, 1);
    for (int t = 0; t < 5; t++) push(order[t], 1, 1'b0);
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      vectors++;
      if (gnt_id !== IDW'(order[t]) || gnt !== NEP'(1 << order[t]) || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL fair_grant%0d: got id=%0d gnt=%b busy=%b, required id=%0d", t, gnt_id, gnt, busy, order[t]);
      end
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL fair_gap%0d: got busy=%b done=%b, required idle gap", t, busy, done);
      end
      if (t == 4) req = '0;
    end
    @(negedge clk);
  endtask

  task automatic test_single;
    req = 4'b0001; set_len(0, 3); mem_rdy = 1'b1;
    push(0, 3, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req = '0;
      vectors++;
      if (gnt !== 4'b0001 || mem_vld !== 1'b1 || beat_cnt !== LW'(k)) begin
        miscompares++;
        $display("FAIL single_beat%0d: got gnt=%b vld=%b cnt=%0d, required gnt=0001 vld=1 cnt=%0d",
                 k, gnt, mem_vld, beat_cnt, k);
      end
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || gnt !== '0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_done: got done=%b gnt=%b busy=%b, required 1 0000 0", done, gnt, busy);
    end
    @(negedge clk);
    vectors++;
    if (beat_cnt !== LW'(3)) begin
      miscompares++;
      $display("FAIL single_hold: got cnt=%0d, required 3", beat_cnt);
    end
  endtask

  task automatic test_backpressure;
    logic [3:0] rdy_pat = 4'b1010;
    int exp_cnt[4] = '{0, 0, 1, 1};
    req = 4'b0010; set_len(1, 2); mem_rdy = 1'b0;
    push(1, 2, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req = '0;
      vectors++;
      if (busy !== 1'b1 || beat_cnt !== LW'(exp_cnt[k])) begin
        miscompares++;
        $display("FAIL bp_cycle%0d: got busy=%b cnt=%0d, required busy=1 cnt=%0d", k, busy, beat_cnt, exp_cnt[k]);
      end
      mem_rdy = rdy_pat[k];
    end
    @(negedge clk);
    mem_rdy = 1'b1;
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_done: got done=%b, required 1 after 4th cycle", done);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_len;
    req = 4'b0100; set_len(2, 0);
    push(2, 0, 1'b0);
    @(negedge clk);
    req = '0;
    vectors++;
    if (done !== 1'b1 || gnt !== '0 || mem_vld !== 1'b0 || busy !== 1'b0 || beat_cnt !== '0) begin
      miscompares++;
      $display("FAIL zlp: got done=%b gnt=%b vld=%b busy=%b cnt=%0d, required 1 0000 0 0 0",
               done, gnt, mem_vld, busy, beat_cnt);
    end
    @(negedge clk);
    // last is now 2, so requester 3 outranks 0 and 1.
    req = 4'b1011; set_len(3, 1); set_len(0, 1); set_len(1, 1);
    push(3, 1, 1'b0);
    @(negedge clk);
    req = '0;
    vectors++;
    if (gnt_id !== 2'd3 || gnt !== 4'b1000) begin
      miscompares++;
      $display("FAIL zlp_last: got id=%0d gnt=%b, required id=3 gnt=1000", gnt_id, gnt);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_abort;
    req = 4'b0001; set_len(0, 5); mem_rdy = 1'b1;
    push(0, 2, 1'b1);
    @(negedge clk);
    req = '0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || err !== 1'b1 || beat_cnt !== LW'(2)) begin
      miscompares++;
      $display("FAIL abort_mid: got done=%b err=%b cnt=%0d, required 1 1 2", done, err, beat_cnt);
    end
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_idle: got busy=%b done=%b, required 0 0", busy, done);
    end
    abort = 1'b0;
    req = 4'b0010; set_len(1, 2);
    push(1, 2, 1'b0);
    @(negedge clk);
    req = '0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    vectors++;
    if (done !== 1'b1 || err !== 1'b0 || beat_cnt !== LW'(2)) begin
      miscompares++;
      $display("FAIL abort_final: got done=%b err=%b cnt=%0d, required 1 0 2", done, err, beat_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bit seen;
    req = 4'b0100; set_len(2, 6); mem_rdy = 1'b1;
    @(negedge clk);
    req = '0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({gnt, gnt_id, busy, mem_vld, beat_cnt, done, err} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: got gnt=%b id=%0d busy=%b vld=%b cnt=%0d done=%b err=%b, required all 0",
               gnt, gnt_id, busy, mem_vld, beat_cnt, done, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < NEP; i++) set_len(i, 1);
    push(0, 1, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        seen = 1'b1;
        req = '0;
        vectors++;
        if (gnt_id !== 2'd0 || gnt !== 4'b0001) begin
          miscompares++;
          $display("FAIL reset_regrant: got id=%0d gnt=%b, required id=0 gnt=0001", gnt_id, gnt);
        end
      end
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL reset_regrant_timeout: got busy=0 for 10 cycles, required a grant");
    end
    req = '0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_fairness;
    test_single;
    test_backpressure;
    test_zero_len;
    test_abort;
    test_reset_mid;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: got %0d pending transfers, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
